spi_frame_sequencer: RTL and testbench
======================================

// Module: spi_frame_sequencer
// PURPOSE
//  Upstream feeder for the SPI master: buffers outgoing bytes in a TX FIFO tagged with end-of-frame.
//  Hands bytes to the master one at a time under CS hold, and collects returned MISO bytes in an RX FIFO.
//  Starts a frame only once that frame is fully queued, so the master never underruns mid-frame.
//  Sits on the CTRL_CLK domain between the user logic and the master.
// PARAMETERS
//  TX_DEPTH   8  TX FIFO entries (power of 2); each entry is 8 data bits plus 1 LAST bit
//  RX_DEPTH   8  RX FIFO entries (power of 2), 8 bits each
//  GAP_CYCLES 4  CTRL_CLK cycles with M_CS_HOLD low between frames (>=1)
// PORTS
//  CTRL_CLK     in   1  single clock
//  RST          in   1  synchronous reset, active-high
//  TX_WR_EN     in   1  push {TX_LAST,TX_WR_DATA}; ignored when TX_FULL
//  TX_WR_DATA   in   8  byte to transmit
//  TX_LAST      in   1  byte closes a frame
//  TX_FULL      out  1  TX FIFO full
//  RX_RD_EN     in   1  pop RX FIFO; ignored when RX_EMPTY
//  RX_RD_DATA   out  8  RX FIFO head (show-ahead, valid while !RX_EMPTY)
//  RX_EMPTY     out  1  RX FIFO empty
//  RX_OVF       out  1  sticky: a received byte was dropped (cleared only by RST)
//  BUSY         out  1  high in every state except IDLE
//  M_START      out  1  one-cycle pulse: master starts shifting M_MOSI_DATA
//  M_MOSI_DATA  out  8  byte for the master, stable from LOAD until next LOAD
//  M_CS_HOLD    out  1  keep CS asserted; high from first LOAD to last M_DONE of a frame
//  M_DONE       in   1  one-cycle pulse from master: byte exchanged
//  M_MISO_DATA  in   8  received byte, valid in the M_DONE cycle
// BEHAVIOUR
//  Reset: all outputs registered. TX_FULL=0, RX_EMPTY=1, RX_OVF=0, BUSY=0, M_START=0, M_CS_HOLD=0,
//   M_MOSI_DATA=8'h00. FIFOs emptied, frame_cnt=0, FSM=IDLE. Reset mid-frame aborts the frame; CS drops at the next edge.
//  FIFOs: ptrs carry one extra wrap bit; full = MSBs differ & rest equal; empty = ptrs equal.
//   A write when full or a read when empty has no effect. A simultaneous push+pop at full is legal
//   only for TX pop by the FSM plus TX_WR_EN when not full.
//  frame_cnt: +1 on an accepted push with TX_LAST=1; -1 on an FSM pop of a LAST entry; both together leave it unchanged.
//  FSM states:
//   IDLE  : if frame_cnt!=0 -> LOAD.
//   LOAD  : pop TX head; M_MOSI_DATA<=data; last_r<=LAST; M_CS_HOLD<=1 -> START.
//   START : M_START=1 for exactly this cycle -> WAIT.
//   WAIT  : on M_DONE: push M_MISO_DATA to RX (if RX full: drop byte, RX_OVF<=1);
//           last_r ? (M_CS_HOLD<=0, gap_cnt<=0, -> GAP) : -> LOAD. M_DONE in other states is ignored.
//   GAP   : gap_cnt++; at gap_cnt==GAP_CYCLES-1 -> IDLE.
//  Latency: a LAST byte is accepted at edge N -> IDLE sees frame_cnt at N+1 -> LOAD -> M_START high in cycle N+3.
//   Per-byte overhead beyond the master time: 2 cycles (LOAD, START) after M_DONE.
//  A user RX pop and an FSM push in the same cycle are both honoured, including at full
//   (the pop frees the slot, so no overflow).
//  The TX FIFO may be written during a frame. Bytes of the next frame are not sent until its LAST byte has been queued.
// TESTING
//  1 byte frame 8'hA5 LAST, master model echoes 8'h3C -> one M_START, M_CS_HOLD high until M_DONE+1, RX_RD_DATA=8'h3C.
//  3-byte frame 11,22,33 (LAST on 33) -> three M_START pulses, CS held across all; RX holds the echoes in order; then 4 idle cycles with M_CS_HOLD=0.
//  Push 11,22 without LAST -> BUSY stays 0, no M_START. Then push 33 LAST -> the frame starts at N+3.
//  Fill TX with 8 entries -> TX_FULL=1. A 9th push is ignored. Pop to 7 entries -> TX_FULL=0.
//  RX never read, 9 one-byte frames -> 8 bytes retained, RX_OVF=1 after the 9th M_DONE, stays 1 until RST.
//  RST asserted in WAIT of a 3-byte frame -> next edge: M_CS_HOLD=0, BUSY=0, RX_EMPTY=1; a late M_DONE is ignored.

Source files
------------

// File: rtl/spi_frame_sequencer.sv
// Feeds whole frames from a LAST-tagged TX FIFO to the SPI master under CS hold,
// and collects the bytes returned by the master in an RX FIFO.
module spi_frame_sequencer #(
  parameter int TX_DEPTH   = 8,
  parameter int RX_DEPTH   = 8,
  parameter int GAP_CYCLES = 4
) (
  input  logic       ctrlClk_i,
  input  logic       rst_i,
  input  logic       txWrEn_i,
  input  logic [7:0] txWrData_i,
  input  logic       txLast_i,
  output logic       txFull_o,
  input  logic       rxRdEn_i,
  output logic [7:0] rxRdData_o,
  output logic       rxEmpty_o,
  output logic       rxOvf_o,
  output logic       busy_o,
  output logic       mStart_o,
  output logic [7:0] mMosiData_o,
  output logic       mCsHold_o,
  input  logic       mDone_i,
  input  logic [7:0] mMisoData_i
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int GW    = $clog2(GAP_CYCLES) + 1;

  localparam logic [TX_AW:0] TX_ONE   = {{TX_AW{1'b0}}, 1'b1};
  localparam logic [RX_AW:0] RX_ONE   = {{RX_AW{1'b0}}, 1'b1};
  localparam logic [GW-1:0]  GAP_ONE  = {{(GW-1){1'b0}}, 1'b1};
  localparam logic [GW-1:0]  GAP_LAST = GW'(GAP_CYCLES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [8:0]     txMem_q [TX_DEPTH];
  logic [TX_AW:0] txWrPtr_q, txWrPtr_d;
  logic [TX_AW:0] txRdPtr_q, txRdPtr_d;
  logic           txFull_q, txFull_d;
  logic           txEmpty;
  logic           txPush, txPop;
  logic [8:0]     txHead;

  logic [7:0]     rxMem_q [RX_DEPTH];
  logic [RX_AW:0] rxWrPtr_q, rxWrPtr_d;
  logic [RX_AW:0] rxRdPtr_q, rxRdPtr_d;
  logic           rxFull_q, rxFull_d;
  logic           rxEmpty_q, rxEmpty_d;
  logic           rxOvf_q, rxOvf_d;
  logic           rxWriteReq, rxPush, rxPop;

  logic [TX_AW:0] frameCnt_q, frameCnt_d;

  logic [2:0]     state_q, state_d;
  logic [GW-1:0]  gapCnt_q, gapCnt_d;
  logic           lastR_q, lastR_d;
  logic [7:0]     mosi_q, mosi_d;
  logic           cs_q, cs_d;
  logic           start_q, start_d;
  logic           busy_q, busy_d;

  assign txEmpty    = (txWrPtr_q == txRdPtr_q);
  assign txHead     = txMem_q[txRdPtr_q[TX_AW-1:0]];
  assign txPush     = txWrEn_i && !txFull_q;
  assign txPop      = (state_q == S_LOAD) && !txEmpty;

  // A full RX FIFO still accepts the master's byte when the user pops in the same cycle.
  assign rxWriteReq = (state_q == S_WAIT) && mDone_i;
  assign rxPop      = rxRdEn_i && !rxEmpty_q;
  assign rxPush     = rxWriteReq && (!rxFull_q || rxPop);

  always_comb begin
    txWrPtr_d = txWrPtr_q;
    txRdPtr_d = txRdPtr_q;
    if (txPush) txWrPtr_d = txWrPtr_q + TX_ONE;
    if (txPop)  txRdPtr_d = txRdPtr_q + TX_ONE;
    txFull_d = (txWrPtr_d[TX_AW] != txRdPtr_d[TX_AW]) &&
               (txWrPtr_d[TX_AW-1:0] == txRdPtr_d[TX_AW-1:0]);
  end

  always_comb begin
    rxWrPtr_d = rxWrPtr_q;
    rxRdPtr_d = rxRdPtr_q;
    if (rxPush) rxWrPtr_d = rxWrPtr_q + RX_ONE;
    if (rxPop)  rxRdPtr_d = rxRdPtr_q + RX_ONE;
    rxFull_d  = (rxWrPtr_d[RX_AW] != rxRdPtr_d[RX_AW]) &&
                (rxWrPtr_d[RX_AW-1:0] == rxRdPtr_d[RX_AW-1:0]);
    rxEmpty_d = (rxWrPtr_d == rxRdPtr_d);
    rxOvf_d   = rxOvf_q || (rxWriteReq && rxFull_q && !rxPop);
  end

  // Number of complete frames queued; a frame is only launched once its LAST byte is in.
  always_comb begin
    frameCnt_d = frameCnt_q;
    case ({txPush && txLast_i, txPop && txHead[8]})
      2'b10:   frameCnt_d = frameCnt_q + TX_ONE;
      2'b01:   frameCnt_d = frameCnt_q - TX_ONE;
      default: frameCnt_d = frameCnt_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    gapCnt_d = gapCnt_q;
    lastR_d  = lastR_q;
    mosi_d   = mosi_q;
    cs_d     = cs_q;
    start_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frameCnt_q != '0) state_d = S_LOAD;
      end
      S_LOAD: begin
        mosi_d  = txHead[7:0];
        lastR_d = txHead[8];
        cs_d    = 1'b1;
        start_d = 1'b1;
        state_d = S_START;
      end
      S_START: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mDone_i) begin
          if (lastR_q) begin
            cs_d     = 1'b0;
            gapCnt_d = '0;
            state_d  = S_GAP;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_GAP: begin
        gapCnt_d = gapCnt_q + GAP_ONE;
        if (gapCnt_q == GAP_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge ctrlClk_i) begin
    if (txPush) txMem_q[txWrPtr_q[TX_AW-1:0]] <= {txLast_i, txWrData_i};
    if (rxPush) rxMem_q[rxWrPtr_q[RX_AW-1:0]] <= mMisoData_i;
  end

  always_ff @(posedge ctrlClk_i) begin
    if (rst_i) begin
      txWrPtr_q  <= '0;
      txRdPtr_q  <= '0;
      txFull_q   <= 1'b0;
      rxWrPtr_q  <= '0;
      rxRdPtr_q  <= '0;
      rxFull_q   <= 1'b0;
      rxEmpty_q  <= 1'b1;
      rxOvf_q    <= 1'b0;
      frameCnt_q <= '0;
      state_q    <= S_IDLE;
      gapCnt_q   <= '0;
      lastR_q    <= 1'b0;
      mosi_q     <= 8'h00;
      cs_q       <= 1'b0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      txWrPtr_q  <= txWrPtr_d;
      txRdPtr_q  <= txRdPtr_d;
      txFull_q   <= txFull_d;
      rxWrPtr_q  <= rxWrPtr_d;
      rxRdPtr_q  <= rxRdPtr_d;
      rxFull_q   <= rxFull_d;
      rxEmpty_q  <= rxEmpty_d;
      rxOvf_q    <= rxOvf_d;
      frameCnt_q <= frameCnt_d;
      state_q    <= state_d;
      gapCnt_q   <= gapCnt_d;
      lastR_q    <= lastR_d;
      mosi_q     <= mosi_d;
      cs_q       <= cs_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
    end
  end

  assign txFull_o    = txFull_q;
  assign rxRdData_o  = rxMem_q[rxRdPtr_q[RX_AW-1:0]];
  assign rxEmpty_o   = rxEmpty_q;
  assign rxOvf_o     = rxOvf_q;
  assign busy_o      = busy_q;
  assign mStart_o    = start_q;
  assign mMosiData_o = mosi_q;
  assign mCsHold_o   = cs_q;

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Bench for spi_frame_sequencer: an echoing master model plus TX/RX scoreboards,
// with one task per scenario.
module tb_spi_frame_sequencer;

  logic       ctrlClk = 1'b0;
  logic       rst;
  logic       txWrEn;
  logic [7:0] txWrData;
  logic       txLast;
  logic       txFull_o;
  logic       rxRdEn;
  logic [7:0] rxRdData_o;
  logic       rxEmpty_o;
  logic       rxOvf_o;
  logic       busy_o;
  logic       mStart_o;
  logic [7:0] mMosiData_o;
  logic       mCsHold_o;
  logic       mDone;
  logic [7:0] mMisoData;

  int checks = 0;
  int failures = 0;
  int startCount = 0;
  int masterDelay = 1;
  bit masterAuto = 1'b1;

  logic [7:0] txExp[$];
  logic [7:0] rxExp[$];

  localparam logic [7:0] ECHO_KEY = 8'h99;
  localparam int GAP = 4;

  always #5 ctrlClk = ~ctrlClk;

  spi_frame_sequencer #(.TX_DEPTH(8), .RX_DEPTH(8), .GAP_CYCLES(GAP)) dut (
    .ctrlClk_i  (ctrlClk),
    .rst_i      (rst),
    .txWrEn_i   (txWrEn),
    .txWrData_i (txWrData),
    .txLast_i   (txLast),
    .txFull_o   (txFull_o),
    .rxRdEn_i   (rxRdEn),
    .rxRdData_o (rxRdData_o),
    .rxEmpty_o  (rxEmpty_o),
    .rxOvf_o    (rxOvf_o),
    .busy_o     (busy_o),
    .mStart_o   (mStart_o),
    .mMosiData_o(mMosiData_o),
    .mCsHold_o  (mCsHold_o),
    .mDone_i    (mDone),
    .mMisoData_i(mMisoData)
  );

  initial begin
    forever begin
      @(posedge ctrlClk); #1;
      if (mStart_o === 1'b1) startCount++;
    end
  end

  // Master model: checks each launched byte against the TX scoreboard, answers with byte^ECHO_KEY.
  initial begin
    logic [7:0] exp;
    mDone = 1'b0;
    mMisoData = 8'h00;
    forever begin
      @(posedge ctrlClk); #1;
      if (masterAuto && mStart_o === 1'b1) begin
        exp = 8'h00;
        checks++;
        if (txExp.size() == 0) begin
          failures++;
          $display("[TB] FAIL mosi_byte: got %h, no byte expected", mMosiData_o);
        end else begin
          exp = txExp.pop_front();
          if (mMosiData_o !== exp) begin
            failures++;
            $display("[TB] FAIL mosi_byte: got %h, required %h", mMosiData_o, exp);
          end
        end
        checks++;
        if (mCsHold_o !== 1'b1) begin
          failures++;
          $display("[TB] FAIL cs_at_start: got %b, required 1", mCsHold_o);
        end
        repeat (masterDelay) @(posedge ctrlClk);
        #1;
        mDone = 1'b1;
        mMisoData = exp ^ ECHO_KEY;
        @(posedge ctrlClk); #1;
        mDone = 1'b0;
        masterDelay = (masterDelay % 3) + 1;
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic pushTx(input logic [7:0] d, input logic last, input bit track);
    txWrEn = 1'b1;
    txWrData = d;
    txLast = last;
    @(posedge ctrlClk); #1;
    txWrEn = 1'b0;
    txLast = 1'b0;
    if (track) begin
      txExp.push_back(d);
      rxExp.push_back(d ^ ECHO_KEY);
    end
  endtask

  task automatic popRx(output logic [7:0] data, output logic empty);
    data = rxRdData_o;
    empty = rxEmpty_o;
    rxRdEn = 1'b1;
    @(posedge ctrlClk); #1;
    rxRdEn = 1'b0;
  endtask

  task automatic waitCsFall(input int budget, output bit ok);
    logic prev;
    prev = mCsHold_o;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge ctrlClk); #1;
      if (prev === 1'b1 && mCsHold_o === 1'b0) begin
        ok = 1'b1;
        break;
      end
      prev = mCsHold_o;
    end
  endtask

  task automatic waitIdle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (busy_o === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(posedge ctrlClk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge ctrlClk);
    #1;
    checks++;
    if ({txFull_o, rxEmpty_o, rxOvf_o, busy_o, mStart_o, mCsHold_o} !== 6'b010000) begin
      failures++;
      $display("[TB] FAIL reset_flags: full/empty/ovf/busy/start/cs=%b, required 010000",
               {txFull_o, rxEmpty_o, rxOvf_o, busy_o, mStart_o, mCsHold_o});
    end
    checks++;
    if (mMosiData_o !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_mosi: got %h, required 00", mMosiData_o);
    end
    rst = 1'b0;
    @(posedge ctrlClk); #1;
  endtask

  task automatic test_single_byte;
    int s0;
    bit ok;
    logic prevCs;
    logic [7:0] d, exp;
    logic e;
    s0 = startCount;
    pushTx(8'hA5, 1'b1, 1'b1);
    ok = 1'b0;
    prevCs = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge ctrlClk); #1;
      if (rxEmpty_o === 1'b0) begin
        ok = 1'b1;
        break;
      end
      prevCs = mCsHold_o;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL single_rx_timeout: rxEmpty=%b, required 0 within 40 cycles", rxEmpty_o);
    end
    checks++;
    if (prevCs !== 1'b1 || mCsHold_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_cs: cs before/after done=%b/%b, required 1/0", prevCs, mCsHold_o);
    end
    checks++;
    if (startCount - s0 != 1) begin
      failures++;
      $display("[TB] FAIL single_starts: got %0d pulses, required 1", startCount - s0);
    end
    exp = (rxExp.size() != 0) ? rxExp.pop_front() : 8'hxx;
    popRx(d, e);
    checks++;
    if (e !== 1'b0 || d !== exp || d !== 8'h3C) begin
      failures++;
      $display("[TB] FAIL single_rx: got %h empty=%b, required 3C empty=0", d, e);
    end
    checks++;
    if (rxEmpty_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL single_rx_drained: rxEmpty=%b, required 1", rxEmpty_o);
    end
    waitIdle(20, ok);
  endtask

  task automatic test_three_byte;
    int s0, n;
    bit ok;
    logic [7:0] d, exp;
    logic e;
    s0 = startCount;
    pushTx(8'h11, 1'b0, 1'b1);
    pushTx(8'h22, 1'b0, 1'b1);
    pushTx(8'h33, 1'b1, 1'b1);
    waitCsFall(200, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL three_cs_fall: no CS release within 200 cycles, cs=%b", mCsHold_o);
    end
    checks++;
    if (startCount - s0 != 3) begin
      failures++;
      $display("[TB] FAIL three_starts: got %0d pulses at CS release, required 3", startCount - s0);
    end
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy_o === 1'b1 && mCsHold_o === 1'b0) n++;
      else break;
      @(posedge ctrlClk); #1;
    end
    checks++;
    if (n != GAP || busy_o !== 1'b0 || mCsHold_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL three_gap: gap cycles=%0d busy=%b cs=%b, required %0d/0/0", n, busy_o, mCsHold_o, GAP);
    end
    for (int i = 0; i < 3; i++) begin
      exp = (rxExp.size() != 0) ? rxExp.pop_front() : 8'hxx;
      popRx(d, e);
      checks++;
      if (e !== 1'b0 || d !== exp) begin
        failures++;
        $display("[TB] FAIL three_rx%0d: got %h empty=%b, required %h empty=0", i, d, e, exp);
      end
    end
    checks++;
    if (rxEmpty_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL three_rx_drained: rxEmpty=%b, required 1", rxEmpty_o);
    end
  endtask

  task automatic test_wait_for_last;
    int s0;
    bit ok, sawBusy;
    logic [7:0] d, exp;
    logic e;
    s0 = startCount;
    pushTx(8'h11, 1'b0, 1'b1);
    pushTx(8'h22, 1'b0, 1'b1);
    sawBusy = 1'b0;
    repeat (10) begin
      @(posedge ctrlClk); #1;
      if (busy_o !== 1'b0) sawBusy = 1'b1;
    end
    checks++;
    if (sawBusy || startCount != s0) begin
      failures++;
      $display("[TB] FAIL partial_frame_held: busy seen=%b starts=%0d, required 0/0", sawBusy, startCount - s0);
    end
    pushTx(8'h33, 1'b1, 1'b1);
    checks++;
    if (busy_o !== 1'b0 || mStart_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL latency_n: busy=%b start=%b, required 0/0", busy_o, mStart_o);
    end
    @(posedge ctrlClk); #1;
    checks++;
    if (busy_o !== 1'b1 || mStart_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL latency_load: busy=%b start=%b, required 1/0", busy_o, mStart_o);
    end
    @(posedge ctrlClk); #1;
    checks++;
    if (mStart_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL latency_start: start=%b, required 1", mStart_o);
    end
    waitCsFall(200, ok);
    waitIdle(20, ok);
    checks++;
    if (!ok || startCount - s0 != 3) begin
      failures++;
      $display("[TB] FAIL partial_frame_done: idle=%b starts=%0d, required 1/3", ok, startCount - s0);
    end
    for (int i = 0; i < 3; i++) begin
      exp = (rxExp.size() != 0) ? rxExp.pop_front() : 8'hxx;
      popRx(d, e);
      checks++;
      if (e !== 1'b0 || d !== exp) begin
        failures++;
        $display("[TB] FAIL partial_rx%0d: got %h empty=%b, required %h empty=0", i, d, e, exp);
      end
    end
  endtask

  task automatic test_tx_full;
    int s0;
    bit ok;
    logic [7:0] d, exp;
    logic e;
    s0 = startCount;
    for (int i = 0; i < 7; i++) pushTx(8'h40 + 8'(i), 1'b0, 1'b1);
    pushTx(8'h47, 1'b1, 1'b1);
    checks++;
    if (txFull_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL tx_full_set: txFull=%b, required 1", txFull_o);
    end
    pushTx(8'hEE, 1'b1, 1'b0);
    checks++;
    if (txFull_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL tx_full_hold: txFull=%b, required 1", txFull_o);
    end
    @(posedge ctrlClk); #1;
    checks++;
    if (txFull_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL tx_full_clear: txFull=%b after first pop, required 0", txFull_o);
    end
    waitCsFall(400, ok);
    waitIdle(20, ok);
    repeat (10) @(posedge ctrlClk);
    #1;
    checks++;
    if (startCount - s0 != 8 || busy_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL tx_full_ignored: starts=%0d busy=%b, required 8/0", startCount - s0, busy_o);
    end
    for (int i = 0; i < 8; i++) begin
      exp = (rxExp.size() != 0) ? rxExp.pop_front() : 8'hxx;
      popRx(d, e);
      checks++;
      if (e !== 1'b0 || d !== exp) begin
        failures++;
        $display("[TB] FAIL full_rx%0d: got %h empty=%b, required %h empty=0", i, d, e, exp);
      end
    end
  endtask

  task automatic test_rx_overflow;
    bit ok;
    logic [7:0] d, exp;
    logic e;
    for (int f = 0; f < 9; f++) begin
      pushTx(8'h80 + 8'(f), 1'b1, 1'b1);
      waitCsFall(100, ok);
      checks++;
      if (!ok || rxOvf_o !== (f == 8)) begin
        failures++;
        $display("[TB] FAIL ovf_frame%0d: done=%b rxOvf=%b, required 1/%b", f, ok, rxOvf_o, f == 8);
      end
      waitIdle(20, ok);
    end
    void'(rxExp.pop_back());
    repeat (20) @(posedge ctrlClk);
    #1;
    for (int i = 0; i < 8; i++) begin
      exp = (rxExp.size() != 0) ? rxExp.pop_front() : 8'hxx;
      popRx(d, e);
      checks++;
      if (e !== 1'b0 || d !== exp) begin
        failures++;
        $display("[TB] FAIL ovf_rx%0d: got %h empty=%b, required %h empty=0", i, d, e, exp);
      end
    end
    checks++;
    if (rxEmpty_o !== 1'b1 || rxOvf_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ovf_sticky: rxEmpty=%b rxOvf=%b, required 1/1", rxEmpty_o, rxOvf_o);
    end
  endtask

  task automatic test_reset_mid_frame;
    bit ok;
    masterAuto = 1'b0;
    pushTx(8'h11, 1'b0, 1'b0);
    pushTx(8'h22, 1'b0, 1'b0);
    pushTx(8'h33, 1'b1, 1'b0);
    for (int b = 0; b < 2; b++) begin
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(posedge ctrlClk); #1;
        if (mStart_o === 1'b1) begin
          ok = 1'b1;
          break;
        end
      end
      @(posedge ctrlClk); #1;
      if (b == 0) begin
        mDone = 1'b1;
        mMisoData = 8'h77;
        @(posedge ctrlClk); #1;
        mDone = 1'b0;
      end
    end
    checks++;
    if (!ok || rxEmpty_o !== 1'b0 || mCsHold_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midframe_setup: started=%b rxEmpty=%b cs=%b, required 1/0/1", ok, rxEmpty_o, mCsHold_o);
    end
    rst = 1'b1;
    @(posedge ctrlClk); #1;
    rst = 1'b0;
    checks++;
    if (mCsHold_o !== 1'b0 || busy_o !== 1'b0 || rxEmpty_o !== 1'b1 || rxOvf_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midframe_reset: cs=%b busy=%b rxEmpty=%b rxOvf=%b, required 0/0/1/0",
               mCsHold_o, busy_o, rxEmpty_o, rxOvf_o);
    end
    mDone = 1'b1;
    mMisoData = 8'h55;
    @(posedge ctrlClk); #1;
    mDone = 1'b0;
    repeat (10) @(posedge ctrlClk);
    #1;
    checks++;
    if (rxEmpty_o !== 1'b1 || busy_o !== 1'b0 || mCsHold_o !== 1'b0 || txFull_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL late_done: rxEmpty=%b busy=%b cs=%b txFull=%b, required 1/0/0/0",
               rxEmpty_o, busy_o, mCsHold_o, txFull_o);
    end
    masterAuto = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    txWrEn = 1'b0;
    txWrData = 8'h00;
    txLast = 1'b0;
    rxRdEn = 1'b0;
    test_reset();
    test_single_byte();
    test_three_byte();
    test_wait_for_last();
    test_tx_full();
    test_rx_overflow();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
